// File: rtl/alu_result_fifo.sv
// Registered, back-pressurable result buffer behind the 4-bit ALU.
// Holds {op, zero, data} entries and returns them in order via valid/ready.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_op,
    output logic             out_zero,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam int EW = WIDTH + 3;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;
    logic          in_zero;
    logic [EW-1:0] head;

    // Status comes only from registered occupancy, so no ready path exists.
    assign full      = (cnt == FULL_CNT);
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign in_ready  = ~full;
    assign out_valid = ~empty;

    // A reset cycle never moves data, whatever the handshakes say.
    assign push    = in_valid & in_ready & ~rst;
    assign pop     = out_valid & out_ready & ~rst;
    assign in_zero = ~|in_data;

    assign head     = mem[rd_ptr];
    assign out_data = head[WIDTH-1:0];
    assign out_zero = head[WIDTH];
    assign out_op   = head[WIDTH+2:WIDTH+1];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_op, in_zero, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Bench for alu_result_fifo: directed steps plus random traffic,
// checked against a queue model of an in-order bounded buffer.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_op;
    logic             out_zero;
    logic [AW:0]      count;
    logic             full;
    logic             empty;

    int checks = 0;
    int errors = 0;

    // model entries are {op, zero, data}
    logic [6:0] q[$];
    logic [3:0] popped[$];

    always #5 clk = ~clk;

    alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_op(out_op), .out_zero(out_zero),
        .count(count), .full(full), .empty(empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(n > 0));
        if (n > 0) begin
            chk("out_data", 32'(out_data), 32'(q[0][3:0]));
            chk("out_zero", 32'(out_zero), 32'(q[0][4]));
            chk("out_op", 32'(out_op), 32'(q[0][6:5]));
        end
    endtask

    // One clock cycle: drive, check, clock, update model.
    task automatic cyc(input logic r, input logic iv, input logic [3:0] d,
                       input logic [1:0] op, input logic ordy);
        bit acc;
        bit pp;
        rst = r; in_valid = iv; in_data = d; in_op = op; out_ready = ordy;
        #1;
        if (!r) check_state();
        acc = !r && iv && (q.size() < DEPTH);
        pp  = !r && ordy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
        end else begin
            if (pp) begin
                popped.push_back(q[0][3:0]);
                void'(q.pop_front());
            end
            if (acc) q.push_back({op, (d == 4'h0), d});
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (q.size() > 0 && k < budget) begin
            cyc(0, 0, 4'h0, 2'b00, 1);
            k++;
        end
        chk("drain_done", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [3:0] dd [4];
        logic [1:0] dop [4];
        logic [3:0] exp_d [4];
        logic       exp_z [4];
        int nxt;
        int guard;
        bit tog;

        dd    = '{4'h3, 4'h0, 4'hA, 4'hF};
        dop   = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp_d = '{4'h3, 4'h0, 4'hA, 4'hF};
        exp_z = '{1'b0, 1'b1, 1'b0, 1'b0};
        rst = 1; in_valid = 0; in_data = 0; in_op = 0; out_ready = 0;
        @(negedge clk);

        // reset then idle with out_ready held
        cyc(1, 0, 4'h0, 2'b00, 0);
        cyc(1, 0, 4'h0, 2'b00, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 4'h0, 2'b00, 1);
        chk("idle_count", 32'(count), 32'd0);

        // fill, reject fifth, drain in order
        for (int i = 0; i < 4; i++) cyc(0, 1, dd[i], dop[i], 0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_count", 32'(count), 32'd4);
        cyc(0, 1, 4'h5, 2'b01, 0);
        chk("reject_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_data", 32'(out_data), 32'(exp_d[i]));
            chk("drain_zero", 32'(out_zero), 32'(exp_z[i]));
            cyc(0, 0, 4'h0, 2'b00, 1);
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // simultaneous push/pop at count 2
        cyc(0, 1, 4'h1, 2'b00, 0);
        cyc(0, 1, 4'h2, 2'b01, 0);
        cyc(0, 1, 4'h7, 2'b10, 1);
        chk("pp_count", 32'(count), 32'd2);
        chk("pp_head", 32'(out_data), 32'h2);
        cyc(0, 0, 4'h0, 2'b00, 1);
        chk("pp_next", 32'(out_data), 32'h7);
        drain(8);

        // full with both handshakes: pop only, then push succeeds
        for (int i = 0; i < 4; i++) cyc(0, 1, 4'(i + 8), 2'b11, 0);
        cyc(0, 1, 4'h9, 2'b00, 1);
        chk("fullpp_count", 32'(count), 32'd3);
        cyc(0, 1, 4'hE, 2'b00, 0);
        chk("after_push_count", 32'(count), 32'd4);
        drain(8);

        // wrap-around stream of 0..9
        popped.delete();
        nxt = 0; guard = 0; tog = 1;
        while ((nxt < 10 || q.size() > 0) && guard < 100) begin
            if (nxt < 10 && q.size() < DEPTH) begin
                cyc(0, 1, 4'(nxt), 2'(nxt), tog);
                nxt++;
            end else begin
                cyc(0, nxt < 10, 4'(nxt), 2'(nxt), tog);
            end
            tog = ~tog;
            guard++;
        end
        chk("wrap_n", 32'(popped.size()), 32'd10);
        for (int i = 0; i < popped.size() && i < 10; i++)
            chk("wrap_order", 32'(popped[i]), 32'(i));

        // reset mid-operation
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'(i + 1), 2'b00, 0);
        cyc(1, 1, 4'h6, 2'b00, 1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        cyc(0, 1, 4'hC, 2'b10, 0);
        chk("post_rst_head", 32'(out_data), 32'hC);
        drain(8);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0), 1'($urandom),
                4'($urandom), 2'($urandom), 1'($urandom));
        end
        drain(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Registered result buffer downstream of the 4-bit combinational ALU. Each cycle it can capture one ALU result word together with the opcode that produced it and a zero flag, hold up to DEPTH entries, and return them in order through a valid/ready handshake. It gives the purely combinational ALU a clocked, back-pressurable output stage. It also keeps a small formal-friendly state footprint for CNF extraction.

## Interface
- DEPTH, 4: number of entries; power of two, 2..8.
- WIDTH, 4: result width; matches the ALU Y output.
- AW, 2: pointer width, log2(DEPTH).

- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU result presented this cycle.
- in_ready  output  1  buffer can accept a word this cycle.
- in_data  input  WIDTH  ALU result Y.
- in_op  input  2  ALU Op that produced in_data (00 AND, 01 OR, 10 XOR, 11 NOT A).
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes head this cycle.
- out_data  output  WIDTH  head result.
- out_op  output  2  head opcode.
- out_zero  output  1  head result was all-zero when written.
- count  output  AW+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

## Operation
- Push: `push = in_valid & in_ready`. On push, store {in_op, zero, in_data} at wr_ptr, where zero = ~|in_data. Then advance wr_ptr modulo DEPTH.
- Pop: `pop = out_valid & out_ready`. On pop, advance rd_ptr modulo DEPTH.
- in_ready = ~full. It does not depend on out_ready, so there is no combinational ready path. A push while full is never accepted, even with a simultaneous pop.
- out_valid = ~empty. out_data, out_op and out_zero are the storage contents at rd_ptr (show-ahead). They remain stable while out_valid=1 and out_ready=0.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push+pop together, or on neither.
- Wrap-around: pointers roll from DEPTH−1 to 0. Ordering is preserved across the wrap.
- Push and pop in the same cycle when 0 < count < DEPTH: both take effect. Occupancy is unchanged.
- Push while empty: no bypass. The word appears at the output on the next cycle.
- Storage is not reset. Only pointers and count are reset. Outputs are don't-care while out_valid=0.
- Inputs in_data and in_op are ignored when in_valid=0 or in_ready=0.

## Timing
- Reset values, one cycle after rst is sampled high:
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0, in_ready = 1, out_valid = 0.
- Reset mid-operation discards all entries regardless of in_valid/out_ready in that cycle. No push or pop occurs in a reset cycle.
- Latency: a word pushed at edge N is visible on out_* after edge N (out_valid high in cycle N+1). Minimum one cycle.
- Throughput: one push and one pop per cycle sustained.
- full, empty, count, in_ready and out_valid are all functions of registered state only.

## Test plan
- Reset then idle: rst=1 for 2 cycles → count=0, empty=1, in_ready=1, out_valid=0. Hold out_ready=1 with no pushes → count stays 0.
- Fill and drain (out_ready=0):
  - Push Y=4'h3/Op=00, 4'h0/01, 4'hA/10, 4'hF/11 → full=1, in_ready=0, count=4.
  - Present a 5th word 4'h5 → it is not stored.
  - Then out_ready=1 → outputs 3,0,A,F in order, with out_zero high only for 4'h0. Then empty=1.
- Simultaneous push/pop at count=2: push 4'h7 and pop together → count stays 2. The popped word is the oldest; 4'h7 emerges after the remaining entry.
- Full with out_ready=1 and in_valid=1: no push that cycle, one pop → count=3. A push on the next cycle succeeds.
- Wrap-around: stream 10 words 0..9 with out_ready toggling 1,0,1,0 → all 10 emerge in order with no loss or duplication. in_ready is never high while count=4.
- Reset while count=3 with in_valid=1 and out_ready=1 → next cycle count=0 and out_valid=0. A subsequent push of 4'hC is the first word out.
